// File: rtl/ibex_pkg.sv
// -----------------------------------------------------------------------------
// ibex_pkg
// Shared constants and types for the IF/ID dummy-instruction handover stage.
//   IbexMaxConsecDummyDefault : default number of back-to-back dummies allowed
//                               before one fetch slot is forced
//   ConsecCntW                : width of the consecutive-dummy counter
//   DummyPerfCntW             : width of the optional inserted-dummy counter
//   if_id_slot_t              : payload held in the single IF/ID slot
// -----------------------------------------------------------------------------
package ibex_pkg;

   localparam int unsigned IbexMaxConsecDummyDefault = 4;
   localparam int unsigned ConsecCntW                = 4;
   localparam int unsigned DummyPerfCntW             = 16;

   typedef struct packed {
      logic [31:0] rdata;
      logic [31:0] pc;
      logic        is_dummy;
      logic        err;
   } if_id_slot_t;

endpackage

// File: rtl/ibex_sat_counter.sv
// -----------------------------------------------------------------------------
// ibex_sat_counter
// Up-counter that sticks at MaxVal instead of wrapping.
// Ports:
//   clk_i  : clock
//   rst_i  : synchronous active-high reset, clears the count
//   clr_i  : synchronous clear (wins over en_i)
//   en_i   : increment by one, saturating at MaxVal
//   cnt_o  : current count
// -----------------------------------------------------------------------------
module ibex_sat_counter
   import ibex_pkg::*;
#(
   parameter int unsigned       Width  = ConsecCntW,
   parameter logic [Width-1:0]  MaxVal = '1
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             clr_i,
   input  logic             en_i,
   output logic [Width-1:0] cnt_o
);

   logic [Width-1:0] cnt_q;

   function automatic logic [Width-1:0] sat_inc(input logic [Width-1:0] v);
      return (v >= MaxVal) ? v : v + Width'(1);
   endfunction

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         cnt_q <= '0;
      end else if (clr_i) begin
         cnt_q <= '0;
      end else if (en_i) begin
         cnt_q <= sat_inc(cnt_q);
      end
   end

   assign cnt_o = cnt_q;

endmodule

// File: rtl/ibex_if_dummy_stage.sv
// -----------------------------------------------------------------------------
// ibex_if_dummy_stage
// Single-entry IF/ID handover slot that merges the fetch stream with dummy
// instructions from the dummy instruction generator. A consecutive-dummy
// guard forces one fetch after MaxConsecDummy dummies so fetch never starves.
//
// Optional feature macro: IBEX_DUMMY_PERF_CNT_EN adds dummy_cnt_o, a 16-bit
// saturating count of inserted dummies (cleared by reset only).
//
// Ports:
//   clk_i, rst_i          : clock, synchronous active-high reset
//   fetch_*_i             : offered fetch word (valid, data, pc, bus error)
//   fetch_ready_o         : fetch word consumed this cycle
//   insert_dummy_instr_i  : generator wants a dummy inserted
//   dummy_instr_data_i    : dummy instruction word
//   dummy_ready_o         : slot could take a dummy this cycle
//   id_ready_i            : ID consumes the slot contents this cycle
//   flush_i               : kill the slot
//   instr_*_id_o, pc_id_o : slot contents towards ID
//   dummy_cnt_o           : inserted-dummy count (feature macro only)
// -----------------------------------------------------------------------------
module ibex_if_dummy_stage
   import ibex_pkg::*;
#(
   parameter int unsigned MaxConsecDummy = IbexMaxConsecDummyDefault
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        fetch_valid_i,
   input  logic [31:0] fetch_rdata_i,
   input  logic [31:0] fetch_pc_i,
   input  logic        fetch_err_i,
   output logic        fetch_ready_o,
   input  logic        insert_dummy_instr_i,
   input  logic [31:0] dummy_instr_data_i,
   output logic        dummy_ready_o,
   input  logic        id_ready_i,
   input  logic        flush_i,
   output logic        instr_valid_id_o,
   output logic [31:0] instr_rdata_id_o,
   output logic [31:0] pc_id_o,
   output logic        instr_is_dummy_o,
   output logic        instr_fetch_err_o
`ifdef IBEX_DUMMY_PERF_CNT_EN
   ,
   output logic [DummyPerfCntW-1:0] dummy_cnt_o
`endif
);

   localparam logic [ConsecCntW-1:0] MaxConsec = ConsecCntW'(MaxConsecDummy);

   logic                  valid_q;
   if_id_slot_t           slot_q;
   logic [ConsecCntW-1:0] consec_q;

   logic slot_free;
   logic guard;
   logic dummy_ok;
   logic take_dummy;
   logic take_fetch;

   // Slot can be refilled when empty or drained by ID this cycle. Reset is
   // folded in here so both readies read 0 while rst_i is high.
   assign slot_free  = (~valid_q | id_ready_i) & ~rst_i;
   assign guard      = (consec_q == MaxConsec);

   // dummy_ok deliberately ignores insert_dummy_instr_i: the generator uses
   // this ready to advance its own counter even when it is not inserting.
   assign dummy_ok   = slot_free & ~flush_i & ~guard;
   assign take_dummy = dummy_ok & insert_dummy_instr_i;
   assign take_fetch = slot_free & ~flush_i & fetch_valid_i & ~take_dummy;

   assign dummy_ready_o = dummy_ok;
   assign fetch_ready_o = take_fetch;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         valid_q <= 1'b0;
         slot_q  <= '0;
      end else if (flush_i) begin
         valid_q         <= 1'b0;
         slot_q.is_dummy <= 1'b0;
      end else if (take_dummy) begin
         // Dummy borrows the PC of the fetch it is displacing.
         valid_q        <= 1'b1;
         slot_q.rdata    <= dummy_instr_data_i;
         slot_q.pc       <= fetch_pc_i;
         slot_q.is_dummy <= 1'b1;
         slot_q.err      <= 1'b0;
      end else if (take_fetch) begin
         valid_q         <= 1'b1;
         slot_q.rdata    <= fetch_rdata_i;
         slot_q.pc       <= fetch_pc_i;
         slot_q.is_dummy <= 1'b0;
         slot_q.err      <= fetch_err_i;
      end else if (slot_free) begin
         // Drained with nothing to refill: data registers keep stale values.
         valid_q <= 1'b0;
      end
   end

   ibex_sat_counter #(
      .Width  (ConsecCntW),
      .MaxVal (MaxConsec)
   ) u_consec_cnt (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .clr_i (take_fetch | flush_i),
      .en_i  (take_dummy),
      .cnt_o (consec_q)
   );

`ifdef IBEX_DUMMY_PERF_CNT_EN
   ibex_sat_counter #(
      .Width  (DummyPerfCntW),
      .MaxVal ({DummyPerfCntW{1'b1}})
   ) u_perf_cnt (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .clr_i (1'b0),
      .en_i  (take_dummy),
      .cnt_o (dummy_cnt_o)
   );
`endif

   assign instr_valid_id_o  = valid_q;
   assign instr_rdata_id_o  = slot_q.rdata;
   assign pc_id_o           = slot_q.pc;
   assign instr_is_dummy_o  = slot_q.is_dummy;
   assign instr_fetch_err_o = slot_q.err;

endmodule
